// File: rtl/leo_sprite_fetch.sv
// leo_sprite_fetch: turns VGA draw coordinates plus Leo's position and
// animation state into a sprite-sheet ROM address, then pipelines the
// returned colour index to the palette stage with a sprite_on qualifier.
// Fixed 3-Clk latency from DrawX/DrawY to palette_index/sprite_on.
//
// Ports:
//   Clk, Reset            pixel clock, synchronous active-high reset
//   DrawX, DrawY          current VGA column/row
//   SpriteX, SpriteY      Leo top-left column/row
//   moving, jumping       motion requests (jumping has priority)
//   facing_left           direction, latched at frame tick (flip build only)
//   vsync                 rising edge = frame tick
//   rom_addr              sprite-sheet ROM address (registered)
//   rom_data              ROM read data, valid 1 Clk after rom_addr
//   palette_index         colour index to palette lookup (registered)
//   sprite_on             1 = opaque Leo pixel (registered)
//   anim_state            00 STAND, 01 WALK, 10 JUMP
//
// Build option: define LEO_SPRITE_FLIP_EN to mirror the sprite horizontally
// while the latched facing_left is set.

module leo_sprite_fetch #(
    parameter int unsigned SPRITE_W        = 32,
    parameter int unsigned SPRITE_H        = 32,
    parameter int unsigned WALK_FRAMES     = 2,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned ADDR_W          = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic              moving,
    input  logic              jumping,
    input  logic              facing_left,
    input  logic              vsync,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        palette_index,
    output logic              sprite_on,
    output logic [1:0]        anim_state
);

    localparam int unsigned COL_W  = $clog2(SPRITE_W);
    localparam int unsigned ROW_W  = $clog2(SPRITE_H);
    localparam int unsigned FSEL_W = $clog2(WALK_FRAMES + 2);
    localparam int unsigned WF_W   = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
    localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [1:0] {
        ST_STAND = 2'b00,
        ST_WALK  = 2'b01,
        ST_JUMP  = 2'b10
    } anim_e;

    anim_e             state_q;
    logic [WF_W-1:0]   walk_frame_q;
    logic [STEP_W-1:0] step_q;
    logic              vsync_prev_q;
    logic              hit_d1_q;
    logic              hit_d2_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [3:0]        palette_index_q;
    logic              sprite_on_q;

    logic              tick;
    logic              hit;
    logic [10:0]       dx, dy, sx, sy, sx_end, sy_end;
    logic [9:0]        col_full, row_full;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_eff;
    logic [ROW_W-1:0]  row;
    logic [FSEL_W-1:0] frame_sel;
    logic [ADDR_W-1:0] rom_addr_d;

    assign tick = vsync & ~vsync_prev_q;

    // Bounding-box test in 11 bits so SpriteX/Y + size never wraps.
    always_comb begin
        dx     = {1'b0, DrawX};
        dy     = {1'b0, DrawY};
        sx     = {1'b0, SpriteX};
        sy     = {1'b0, SpriteY};
        sx_end = sx + 11'(SPRITE_W);
        sy_end = sy + 11'(SPRITE_H);
        hit    = (dx >= sx) && (dx < sx_end) && (dy >= sy) && (dy < sy_end);
    end

    assign col_full = DrawX - SpriteX;
    assign row_full = DrawY - SpriteY;
    assign col      = col_full[COL_W-1:0];
    assign row      = row_full[ROW_W-1:0];

`ifdef LEO_SPRITE_FLIP_EN
    logic facing_q;

    // Facing direction is only taken at frame ticks to avoid mid-frame tearing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            facing_q <= 1'b0;
        end else if (tick) begin
            facing_q <= facing_left;
        end
    end

    assign col_eff = facing_q ? (COL_W'(SPRITE_W - 1) - col) : col;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
    assign col_eff       = col;
`endif

    // Sheet order: stand, walk frames, jump.
    always_comb begin
        frame_sel = '0;
        case (state_q)
            ST_WALK: frame_sel = FSEL_W'(1) + FSEL_W'(walk_frame_q);
            ST_JUMP: frame_sel = FSEL_W'(WALK_FRAMES + 1);
            default: frame_sel = '0;
        endcase
    end

    // Power-of-2 sprite size: frame*W*H + row*W + col is a plain concatenation.
    assign rom_addr_d = hit ? ADDR_W'({frame_sel, row, col_eff}) : '0;

    // Animation FSM and walk sequencing, advanced only on frame ticks.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_STAND;
            walk_frame_q <= '0;
            step_q       <= '0;
        end else if (tick) begin
            if (jumping) begin
                state_q <= ST_JUMP;
            end else if (moving) begin
                state_q <= ST_WALK;
                if (state_q != ST_WALK) begin
                    walk_frame_q <= '0;
                    step_q       <= '0;
                end else if (step_q == STEP_W'(FRAMES_PER_STEP - 1)) begin
                    step_q <= '0;
                    if (walk_frame_q == WF_W'(WALK_FRAMES - 1)) begin
                        walk_frame_q <= '0;
                    end else begin
                        walk_frame_q <= walk_frame_q + WF_W'(1);
                    end
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end else begin
                state_q <= ST_STAND;
            end
        end
    end

    // Address / ROM / palette pipeline; reset flushes every stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vsync_prev_q    <= 1'b0;
            rom_addr_q      <= '0;
            hit_d1_q        <= 1'b0;
            hit_d2_q        <= 1'b0;
            palette_index_q <= 4'd0;
            sprite_on_q     <= 1'b0;
        end else begin
            vsync_prev_q    <= vsync;
            rom_addr_q      <= rom_addr_d;
            hit_d1_q        <= hit;
            hit_d2_q        <= hit_d1_q;
            palette_index_q <= hit_d2_q ? rom_data : 4'd0;
            sprite_on_q     <= hit_d2_q && (rom_data != 4'd0);
        end
    end

    assign rom_addr      = rom_addr_q;
    assign palette_index = palette_index_q;
    assign sprite_on     = sprite_on_q;
    assign anim_state    = state_q;

endmodule
